// File: rtl/mem_access_ctrl_pkg.sv
// Shared memory-access definitions: op encodings, size codes, FSM states and
// the decode helpers used by both the decode stage and the MEM controller.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LBU = 3'b001,
    OP_LH  = 3'b010,
    OP_LHU = 3'b011,
    OP_LW  = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } mem_state_e;

  function automatic logic op_is_store(input mem_op_e op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic op_is_half(input mem_op_e op);
    return op inside {OP_LH, OP_LHU, OP_SH};
  endfunction

  function automatic logic op_is_word(input mem_op_e op);
    return op inside {OP_LW, OP_SW};
  endfunction

  function automatic mem_size_e op_size(input mem_op_e op);
    mem_size_e sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic op_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
    return (op_is_half(op) && addr_lo[0]) || (op_is_word(op) && (addr_lo != 2'b00));
  endfunction

  // Stores are replicated across every lane; the cache picks lanes by size/addr.
  function automatic logic [31:0] store_lanes(input mem_op_e op, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (op)
      OP_SB:   lanes = {4{wdata[7:0]}};
      OP_SH:   lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_ext.sv
// Combinational load formatter: selects the addressed byte/half of the
// returned word and sign- or zero-extends it; stores produce zero.
module load_ext
  import mem_access_ctrl_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = '0;
    case (op)
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'h0, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'h0, half_sel};
      OP_LW:   data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: launches one d_cache request per access,
// waits for addr_ok/data_ok, and formats the load result.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [2:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_stall,
  output logic        addr_err,
  output logic        cpu_data_req,
  output logic        cpu_data_wr,
  output logic [1:0]  cpu_data_size,
  output logic [31:0] cpu_data_addr,
  output logic [31:0] cpu_data_wdata,
  input  logic [31:0] cpu_data_rdata,
  input  logic        cpu_data_addr_ok,
  input  logic        cpu_data_data_ok
);

  mem_state_e  state;
  logic        discard;
  mem_op_e     op_q;
  logic        wr_q;
  mem_size_e   size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  mem_op_e     op_in;
  logic        launch;
  logic        capture;
  logic        kill;
  logic [31:0] load_data;

  assign op_in = mem_op_e'(mem_op);

  assign addr_err = mem_en && (state == ST_IDLE) && op_misaligned(op_in, mem_addr[1:0]);
  assign launch   = (state == ST_IDLE) && mem_en && !flush && !addr_err;

  // A flush arriving in the same cycle as data_ok must already suppress capture.
  always_comb begin
    capture = 1'b0;
    kill    = discard;
    case (state)
      ST_REQ: begin
        capture = cpu_data_addr_ok && cpu_data_data_ok;
        kill    = discard || flush;
      end
      ST_WAIT: begin
        capture = cpu_data_data_ok;
        kill    = discard || flush;
      end
      default: begin
        capture = 1'b0;
        kill    = discard;
      end
    endcase
  end

  load_ext u_load_ext (
    .op      (op_q),
    .addr_lo (addr_q[1:0]),
    .rdata   (cpu_data_rdata),
    .data    (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      discard <= 1'b0;
      op_q    <= OP_LB;
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          discard <= 1'b0;
          if (launch) begin
            op_q    <= op_in;
            wr_q    <= op_is_store(op_in);
            size_q  <= op_size(op_in);
            addr_q  <= mem_addr;
            wdata_q <= store_lanes(op_in, mem_wdata);
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (flush) discard <= 1'b1;
          if (cpu_data_addr_ok) state <= cpu_data_data_ok ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          if (flush) discard <= 1'b1;
          if (cpu_data_data_ok) state <= ST_DONE;
        end
        ST_DONE: begin
          discard <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (capture && !kill) rdata_q <= load_data;
    end
  end

  assign mem_done       = (state == ST_DONE) && !discard;
  assign mem_stall      = mem_en && !addr_err && !flush && !mem_done;
  assign mem_rdata      = rdata_q;
  assign cpu_data_req   = (state == ST_REQ);
  assign cpu_data_wr    = wr_q;
  assign cpu_data_size  = size_q;
  assign cpu_data_addr  = addr_q;
  assign cpu_data_wdata = wdata_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 rst  in  1  reset, synchronous, active-low.
REQ-003 mem_en  in  1  MEM stage holds a load/store this cycle.
REQ-004 mem_op  in  3  access type: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
REQ-005 mem_addr  in  32  byte address of the access.
REQ-006 mem_wdata  in  32  store data, right-aligned.
REQ-007 flush  in  1  exception/flush: discard the current access.
REQ-008 mem_rdata  out  32  extended load result, valid while mem_done=1.
REQ-009 mem_done  out  1  single-cycle pulse: access complete, MEM may advance.
REQ-010 mem_stall  out  1  freeze MEM and all earlier stages.
REQ-011 addr_err  out  1  misaligned access; no cache request is issued.
REQ-012 cpu_data_req  out  1  request to d_cache.
REQ-013 cpu_data_wr  out  1  1 = store.
REQ-014 cpu_data_size  out  2  00 byte, 01 half, 10 word.
REQ-015 cpu_data_addr  out  32  request address.
REQ-016 cpu_data_wdata  out  32  lane-replicated store data.
REQ-017 cpu_data_rdata  in  32  word from d_cache, valid with data_ok.
REQ-018 cpu_data_addr_ok  in  1  request accepted.
REQ-019 cpu_data_data_ok  in  1  data returned / store complete.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-021 In IDLE, mem_en & ~flush & ~addr_err SHALL register op, addr, size and replicated wdata, then move to REQ; all other inputs leave it in IDLE.
REQ-022 cpu_data_req SHALL be 1 only in REQ; cpu_data_wr/size/addr/wdata SHALL come solely from the launch registers and SHALL change only on a launch.
REQ-023 In REQ: addr_ok & data_ok -> DONE; addr_ok only -> WAIT; otherwise stay in REQ with cpu_data_req held at 1.
REQ-024 In WAIT: data_ok -> DONE; otherwise stay in WAIT.
REQ-025 DONE SHALL last exactly one cycle, then return to IDLE; mem_done = (state==DONE) & ~discard.
REQ-026 Data capture SHALL occur on data_ok; extraction uses registered addr[1:0]: LB/LBU select byte addr[1:0], LH/LHU select half addr[1], LW passes the word; LB/LH sign-extend, LBU/LHU zero-extend; stores yield 0.
REQ-027 Store data SHALL be SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW unchanged; size SHALL be 00 for LB/LBU/SB, 01 for LH/LHU/SH, 10 otherwise.
REQ-028 addr_err SHALL be combinational: mem_en & (half op & addr[0] | word op & addr[1:0]!=0), and SHALL be asserted only in IDLE.
REQ-029 mem_stall SHALL be mem_en & ~addr_err & ~flush & ~mem_done.
REQ-030 A flush in REQ or WAIT SHALL NOT withdraw cpu_data_req; the transaction runs to data_ok, a discard flag is set, DONE produces no mem_done, and mem_rdata is not updated.
REQ-031 The discard flag SHALL clear on entry to IDLE.
REQ-032 A hit access SHALL produce mem_done 2 cycles after the IDLE launch cycle, for a 3-cycle MEM occupancy.
REQ-033 data_ok in IDLE or DONE SHALL be ignored.

Reset
REQ-034 With rst=0 at a clock edge: state IDLE, cpu_data_req 0, mem_done 0, discard 0, mem_rdata 0, launch registers 0; an in-flight transaction is abandoned.

Structure
REQ-035 The mem_op encodings, size codes and FSM state encodings SHALL be defined in the shared memory-defines package, which is also used by the decode stage.
REQ-036 Load byte/half selection and extension SHALL be a combinational sub-module, load_ext.

Verification
REQ-037 LW 0x0000_1000, hit: addr_ok & data_ok in the first REQ cycle, rdata 0x8899_AABB -> mem_done in cycle 2 with mem_rdata 0x8899_AABB and mem_stall low only in that cycle.
REQ-038 LB 0x1003, rdata 0x80FF_0000 -> mem_rdata 0xFFFF_FF80; LBU -> 0x0000_0080; LH 0x1002 -> 0xFFFF_80FF.
REQ-039 SH 0x2002, wdata 0x1234_ABCD -> cpu_data_size 01 and wdata 0xABCD_ABCD; addr and wdata stay stable through a 20-cycle miss until data_ok.
REQ-040 LW 0x1001 -> addr_err 1, cpu_data_req never asserted, mem_stall 0.
REQ-041 Read miss, flush in the WAIT cycle after addr_ok: req is not reissued, data_ok after 10 cycles, no mem_done, mem_rdata unchanged, IDLE 2 cycles later.
REQ-042 rst=0 in the middle of WAIT -> next cycle IDLE with all outputs 0, and a new LW launches normally.
